// File: rtl/divider_8by4_seq.sv
// Sequential restoring divider, 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// done pulses 9 clocks after the accepting edge (1 clock for a zero divisor); start is ignored unless idle.
module divider_8by4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       div_zero,
    output logic       q_fits4
);

    localparam int         N_ITER    = 8;
    localparam logic [2:0] LAST_ITER = 3'(N_ITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  q_reg_q, q_reg_d;
    logic [4:0]  r_reg_q, r_reg_d;
    logic [3:0]  d_reg_q, d_reg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  quotient_q, quotient_d;
    logic [3:0]  remainder_q, remainder_d;
    logic        div_zero_q, div_zero_d;
    logic        q_fits4_q, q_fits4_d;
    logic        done_q, done_d;

    logic [4:0]  r_tmp;
    logic [4:0]  r_sub;
    logic [4:0]  r_next;
    logic [7:0]  q_next;
    logic        r_ge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_reg_q     <= 8'd0;
            r_reg_q     <= 5'd0;
            d_reg_q     <= 4'd0;
            cnt_q       <= 3'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 4'd0;
            div_zero_q  <= 1'b0;
            q_fits4_q   <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_reg_q     <= q_reg_d;
            r_reg_q     <= r_reg_d;
            d_reg_q     <= d_reg_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            q_fits4_q   <= q_fits4_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = (divisor != 4'd0) ? CALC : DONE;
            CALC:    if (cnt_q == LAST_ITER) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // r_reg[4] never survives a subtract; folding it into the compare keeps it exact anyway.
    always_comb begin
        r_tmp  = {r_reg_q[3:0], q_reg_q[7]};
        r_ge   = (r_tmp >= {1'b0, d_reg_q}) | r_reg_q[4];
        r_sub  = r_tmp - {1'b0, d_reg_q};
        r_next = r_ge ? r_sub : r_tmp;
        q_next = {q_reg_q[6:0], r_ge};

        q_reg_d     = q_reg_q;
        r_reg_d     = r_reg_q;
        d_reg_d     = d_reg_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        q_fits4_d   = q_fits4_q;
        done_d      = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    q_reg_d = dividend;
                    r_reg_d = 5'd0;
                    d_reg_d = divisor;
                    cnt_d   = 3'd0;
                    if (divisor == 4'd0) begin
                        quotient_d  = 8'hFF;
                        remainder_d = 4'hF;
                        div_zero_d  = 1'b1;
                        q_fits4_d   = 1'b0;
                    end
                end
            end
            CALC: begin
                q_reg_d = q_next;
                r_reg_d = r_next;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST_ITER) begin
                    quotient_d  = q_next;
                    remainder_d = r_next[3:0];
                    div_zero_d  = 1'b0;
                    q_fits4_d   = (q_next[7:4] == 4'd0);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy      = (state_q == CALC);
        done      = done_q;
        quotient  = quotient_q;
        remainder = remainder_q;
        div_zero  = div_zero_q;
        q_fits4   = q_fits4_q;
    end

endmodule

// File: tb/tb_divider_8by4_seq.sv
// Self-checking bench for divider_8by4_seq against a plain-arithmetic reference.
module tb_divider_8by4_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;
    logic       q_fits4;

    int checks   = 0;
    int failures = 0;

    divider_8by4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .q_fits4   (q_fits4)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] a, input logic [3:0] b,
                                  output logic [7:0] q, output logic [3:0] r,
                                  output logic dz, output logic f, output int lat);
        if (b == 4'd0) begin
            q = 8'hFF; r = 4'hF; dz = 1'b1; f = 1'b0; lat = 1;
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 4'(int'(a) % int'(b));
            dz = 1'b0;
            f = (int'(q) < 16);
            lat = 9;
        end
    endfunction

    // Issues one operation from a negedge and returns what was seen up to its done pulse.
    task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int lat, output int bcnt,
                         output logic [7:0] q, output logic [3:0] r, output logic dz, output logic f);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1; bcnt = 0; q = 8'd0; r = 4'd0; dz = 1'b0; f = 1'b0;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k; q = quotient; r = remainder; dz = div_zero; f = q_fits4;
            end
        end
    endtask

    task automatic check_op(input string name, input logic [7:0] a, input logic [3:0] b);
        int lat, bcnt, elat;
        logic [7:0] q, eq;
        logic [3:0] r, er;
        logic dz, f, edz, ef;
        do_op(a, b, lat, bcnt, q, r, dz, f);
        model(a, b, eq, er, edz, ef, elat);
        checks++;
        if (lat !== elat || q !== eq || r !== er || dz !== edz || f !== ef) begin
            failures++;
            $display("FAIL %s %0d/%0d: got lat=%0d q=%0d r=%0d dz=%b f=%b, need lat=%0d q=%0d r=%0d dz=%b f=%b",
                     name, a, b, lat, q, r, dz, f, elat, eq, er, edz, ef);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 4'd0;
        #12;
        checks++;
        if ({busy, done, quotient, remainder, div_zero, q_fits4} !== {2'b00, 8'd0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dz=%b f=%b, need 0 0 0 0 0 1",
                     busy, done, quotient, remainder, div_zero, q_fits4);
        end
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, need 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        logic [7:0] q;
        logic [3:0] r;
        logic dz, f;
        do_op(8'd195, 4'd13, lat, bcnt, q, r, dz, f);
        checks++;
        if (bcnt !== 8) begin
            failures++; $display("FAIL busy_cycles: got %0d need 8", bcnt);
        end
        checks++;
        if (lat !== 9) begin
            failures++; $display("FAIL latency_195_13: got %0d need 9", lat);
        end
        checks++;
        if (q !== 8'd15 || r !== 4'd0 || f !== 1'b1 || dz !== 1'b0) begin
            failures++;
            $display("FAIL result_195_13: got q=%0d r=%0d f=%b dz=%b need 15 0 1 0", q, r, f, dz);
        end
        check_op("basic", 8'd100, 4'd7);
        check_op("basic", 8'd255, 4'd1);
    endtask

    task automatic test_div_zero();
        check_op("div_zero", 8'd37, 4'd0);
        check_op("after_zero", 8'd8, 4'd3);
    endtask

    task automatic test_ignored_start();
        int ndone = 0, dk = -1;
        logic [7:0] q = 8'd0;
        logic [3:0] r = 4'd0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd200; divisor = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin ndone++; dk = k; q = quotient; r = remainder; end
            if (k == 2) begin start = 1'b1; dividend = 8'd50; divisor = 4'd5; end
            else if (k == 3) begin start = 1'b0; dividend = 8'($urandom); divisor = 4'($urandom); end
            else if (k == 5) begin dividend = 8'($urandom); divisor = 4'($urandom_range(1, 15)); end
            else if (k == 8) start = 1'b1;
            else if (k == 9) start = 1'b0;
        end
        checks++;
        if (ndone !== 1 || dk !== 9) begin
            failures++; $display("FAIL single_done: got count=%0d at=%0d need 1 at 9", ndone, dk);
        end
        checks++;
        if (q !== 8'd22 || r !== 4'd2) begin
            failures++; $display("FAIL result_200_9: got q=%0d r=%0d need 22 2", q, r);
        end
        checks++;
        if (busy !== 1'b0 || quotient !== 8'd22 || remainder !== 4'd2) begin
            failures++;
            $display("FAIL output_hold: got busy=%b q=%0d r=%0d need 0 22 2", busy, quotient, remainder);
        end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        @(negedge clk);
        start = 1'b1; dividend = 8'd255; divisor = 4'd15;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_zero, q_fits4} !== {2'b00, 8'd0, 4'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL async_reset: got busy=%b done=%b q=%0d r=%0d dz=%b f=%b need 0 0 0 0 0 1",
                     busy, done, quotient, remainder, div_zero, q_fits4);
        end
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++; $display("FAIL aborted_done: got %0d pulses need 0", ndone);
        end
        check_op("after_reset", 8'd16, 4'd4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            logic [3:0] b;
            b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            check_op("random", 8'($urandom), b);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, elat;
        logic [7:0] q, eq;
        logic [3:0] r, er;
        logic dz, f, edz, ef;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_op(8'(a), 4'(b), lat, bcnt, q, r, dz, f);
                model(8'(a), 4'(b), eq, er, edz, ef, elat);
                checks++;
                if (int'(q) * b + int'(r) != a || int'(r) >= b || dz !== 1'b0) begin
                    failures++;
                    $display("FAIL invariant %0d/%0d: got q=%0d r=%0d dz=%b", a, b, q, r, dz);
                end
                checks++;
                if (lat !== elat || q !== eq || f !== ef) begin
                    failures++;
                    $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d f=%b need lat=%0d q=%0d f=%b",
                             a, b, lat, q, f, elat, eq, ef);
                end
            end
        end
    endtask

    task automatic test_multiplier_feedback();
        int lat, bcnt;
        logic [7:0] q;
        logic [3:0] r;
        logic dz, f;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_op(8'(a * b), 4'(b), lat, bcnt, q, r, dz, f);
                checks++;
                if (int'(q) != a || r !== 4'd0 || f !== 1'b1) begin
                    failures++;
                    $display("FAIL mult_check p=%0d b=%0d: got q=%0d r=%0d f=%b need q=%0d r=0 f=1",
                             a * b, b, q, r, f, a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_multiplier_feedback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider_8by4_seq.md
Name: divider_8by4_seq

Overview:
Sequential restoring divider, the inverse of the team's 4-bit array multiplier. It divides an 8-bit dividend (multiplier product width) by a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder. It resolves one quotient bit per clock under a start/done handshake. It sits beside the multiplier in the arithmetic lab datapath and is used to check products (p / b == a).

Parameters:
N_ITER, 8, number of shift-subtract iterations; equals the dividend width. This value is fixed and is not meant to be overridden.

Ports:
clk  input  1  system clock, rising edge active
rst  input  1  asynchronous reset, active-high
start  input  1  request a division; sampled only in IDLE
dividend  input  8  unsigned dividend, captured on the accepting edge
divisor  input  4  unsigned divisor, captured on the accepting edge
busy  output  1  high while an operation is in progress (CALC)
done  output  1  one-cycle pulse when quotient/remainder are valid
quotient  output  8  unsigned quotient, held until the next accepted start
remainder  output  4  unsigned remainder, held until the next accepted start
div_zero  output  1  divisor was 0 for the last completed operation
q_fits4  output  1  quotient[7:4]==0, i.e. the result is a legal 4-bit multiplier operand

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE. busy=0, done=0, quotient=0, remainder=0, div_zero=0, q_fits4=1. Internal registers: q_reg=0, r_reg=0, d_reg=0, iteration counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 at edge E0: capture q_reg<=dividend, r_reg<=0 (5 bits wide), d_reg<=divisor, counter<=0.
  - If divisor!=0, go to CALC.
  - If divisor==0, go to DONE with quotient<=8'hFF, remainder<=4'hF, div_zero<=1, q_fits4<=0.
  - start=0: stay in IDLE.
- CALC: busy=1. One iteration per edge, E1..E8:
  - r_tmp = {r_reg[3:0], q_reg[7]}; q_reg <= q_reg<<1.
  - If r_tmp >= {1'b0,d_reg}: r_reg <= r_tmp - d_reg and q_reg[0] <= 1. Otherwise r_reg <= r_tmp and q_reg[0] <= 0.
  - Counter increments each iteration. On the edge completing iteration 8 (counter==7), go to DONE and load the outputs: quotient<=final q_reg, remainder<=final r_reg[3:0], div_zero<=0, q_fits4<=(final q_reg[7:4]==0).
- r_reg width: 5 bits is sufficient, since the shifted remainder is at most 2*15-1=29. After subtraction the remainder is always <16, so remainder[3:0] is lossless.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally go to IDLE.
- Latency:
  - Nonzero divisor: done is high in the cycle after E9, i.e. 9 clocks after the accepting edge.
  - Zero divisor: done is high in the cycle after E1.
- Throughput: the earliest next accepted start is the edge that ends the DONE cycle. start during DONE is ignored; start must be presented in IDLE.
- start while busy (CALC) or in DONE: ignored. Operands are not re-sampled and the in-flight operation is unaffected.
- Input changes: dividend/divisor changing after E0 have no effect on the operation in flight.
- Output hold: quotient, remainder, div_zero and q_fits4 keep their last values through IDLE and CALC. They update only on entry to DONE.
- Reset mid-operation: rst asserted in any state immediately forces the reset values, including clearing the outputs. No done pulse is produced for the aborted operation.
- Arithmetic: all values are unsigned. Required invariant when div_zero=0: quotient*divisor + remainder == dividend, and remainder < divisor.

Test Plan:
- Reset, then dividend=195, divisor=13, start for 1 cycle -> busy high for 8 cycles; done pulses 9 cycles after the accept edge; quotient=15, remainder=0, q_fits4=1, div_zero=0.
- dividend=100, divisor=7 -> quotient=14, remainder=2, q_fits4=1. Then dividend=255, divisor=1 -> quotient=255, remainder=0, q_fits4=0.
- dividend=37, divisor=0 -> done 1 cycle after accept; quotient=8'hFF, remainder=4'hF, div_zero=1, q_fits4=0. A following 8/3 -> quotient=2, remainder=2, div_zero=0.
- Start 200/9; pulse start with 50/5 on the 3rd CALC cycle and in the DONE cycle; change the operand inputs mid-CALC -> exactly one done; quotient=22, remainder=2; outputs hold until the next IDLE start.
- Start 255/15; assert rst asynchronously (between edges) after 4 CALC cycles -> busy/done/quotient/remainder go to 0 immediately; no done pulse; the next 16/4 completes normally with quotient=4, remainder=0.
- Exhaustive sweep of all 256x15 nonzero-divisor pairs with back-to-back starts issued in the first legal IDLE cycle -> invariant holds for every pair; q_fits4 matches quotient<16; feeding multiplier(a,b)=p back in returns quotient=a, remainder=0 for all b!=0.
